// File: rtl/keyb_pkg.sv
// Shared constants and helpers for the keyboard matrix scanner.
// Key bit index is row*X_W + col throughout the design.
package keyb_pkg;
   localparam int KEYB_Y_W = 8;
   localparam int KEYB_X_W = 3;

   function automatic int key_idx(input int row, input int col, input int x_w = KEYB_X_W);
      return row * x_w + col;
   endfunction

   // A counter with a single state still needs one bit of storage.
   function automatic int clog2_min1(input int v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

   function automatic int max_i(input int a, input int b);
      return (a > b) ? a : b;
   endfunction
endpackage

// File: rtl/keyb_scan_if.sv
// Keyboard matrix bus: row drive and column sense on the keyboard side,
// debounced mask and change strobe on the consumer side.
interface keyb_scan_if
   import keyb_pkg::*;
#(
   parameter int Y_W = KEYB_Y_W,
   parameter int X_W = KEYB_X_W
);
   logic [X_W-1:0]     x_i;
   logic [Y_W-1:0]     y_oe_o;
   logic [Y_W*X_W-1:0] key_o;
   logic               key_chg_o;
   logic [Y_W*X_W-1:0] key_new_o;

   modport master (input x_i, output y_oe_o, key_o, key_chg_o, key_new_o);
   modport slave  (output x_i, input y_oe_o, key_o, key_chg_o, key_new_o);
endinterface

// File: rtl/keyb_debounce.sv
// Per-key frame debouncer with optional autorepeat.
// Autorepeat is built in when KEYB_SCAN_AUTOREPEAT_EN is defined.
module keyb_debounce
   import keyb_pkg::*;
#(
   parameter int DEBOUNCE     = 4,
   parameter int REPEAT_DELAY = 50,
   parameter int REPEAT_RATE  = 12
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic commit,
   input  logic frame_bit,
   output logic stable,
   output logic key_new,
   output logic key_chg
);
   localparam int CNT_W = clog2_min1(DEBOUNCE);

   logic [CNT_W-1:0] cnt;
   logic             stable_next;
   logic             hit;

   always_comb begin
      stable_next = stable;
      if ((frame_bit != stable) && (cnt == CNT_W'(DEBOUNCE - 1)))
         stable_next = frame_bit;
   end

`ifdef KEYB_SCAN_AUTOREPEAT_EN
   localparam int REP_W = clog2_min1(max_i(REPEAT_DELAY, REPEAT_RATE) + 1);

   logic [REP_W-1:0] rep_cnt;
   logic [REP_W-1:0] rep_cnt_inc;
   logic             rep_phase;
   logic             held;

   // rep_phase selects the initial delay versus the steady repeat period.
   assign held        = stable & stable_next;
   assign rep_cnt_inc = rep_cnt + 1'b1;
   assign hit         = held && (rep_cnt_inc == (rep_phase ? REP_W'(REPEAT_RATE)
                                                           : REP_W'(REPEAT_DELAY)));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rep_cnt   <= '0;
         rep_phase <= 1'b0;
      end else if (commit) begin
         if (!held) begin
            rep_cnt   <= '0;
            rep_phase <= 1'b0;
         end else if (hit) begin
            rep_cnt   <= '0;
            rep_phase <= 1'b1;
         end else begin
            rep_cnt   <= rep_cnt_inc;
         end
      end
   end
`else
   assign hit = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stable  <= 1'b0;
         cnt     <= '0;
         key_new <= 1'b0;
         key_chg <= 1'b0;
      end else begin
         key_new <= 1'b0;
         key_chg <= 1'b0;
         if (commit) begin
            stable  <= stable_next;
            if ((frame_bit == stable) || (stable_next != stable))
               cnt <= '0;
            else
               cnt <= cnt + 1'b1;
            key_new <= (stable_next & ~stable) | hit;
            key_chg <= (stable_next ^ stable) | hit;
         end
      end
   end
endmodule

// File: rtl/keyb_scan.sv
// Single-clock matrix keyboard scanner: prescaled row drive, column sampling,
// whole-frame capture and per-key debounce (autorepeat: KEYB_SCAN_AUTOREPEAT_EN).
module keyb_scan
   import keyb_pkg::*;
#(
   parameter int Y_W          = KEYB_Y_W,
   parameter int X_W          = KEYB_X_W,
   parameter int SCAN_DIV     = 12500,
   parameter int DEBOUNCE     = 4,
   parameter int REPEAT_DELAY = 50,
   parameter int REPEAT_RATE  = 12
) (
   input  logic         clk_i,
   input  logic         rst_i,
   keyb_scan_if.master  bus
);
   localparam int DIV_W  = clog2_min1(SCAN_DIV);
   localparam int ROW_W  = clog2_min1(Y_W);
   localparam int N_KEYS = Y_W * X_W;

   logic [X_W-1:0]    x_p0, x_p1;
   logic [DIV_W-1:0]  div_cnt;
   logic [ROW_W-1:0]  row;
   logic [N_KEYS-1:0] raw, raw_merged, frame;
   logic              commit;
   logic              sample, last_row;
   logic [N_KEYS-1:0] stable, new_hit, chg_hit;

   assign sample   = (div_cnt == DIV_W'(SCAN_DIV - 1));
   assign last_row = (row == ROW_W'(Y_W - 1));

   // The frame snapshot must include the row being sampled on this very clock.
   always_comb begin
      raw_merged = raw;
      raw_merged[row*X_W +: X_W] = x_p1;
   end

   // Stage boundary: x_i -> x_p0 -> x_p1, inverted so pressed reads as 1.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         x_p0    <= '0;
         x_p1    <= '0;
         div_cnt <= '0;
         row     <= '0;
         raw     <= '0;
         frame   <= '0;
         commit  <= 1'b0;
      end else begin
         x_p0   <= ~bus.x_i;
         x_p1   <= x_p0;
         commit <= 1'b0;
         if (sample) begin
            div_cnt <= '0;
            row     <= last_row ? '0 : row + 1'b1;
            raw     <= raw_merged;
            if (last_row) begin
               frame  <= raw_merged;
               commit <= 1'b1;
            end
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end
      end
   end

   assign bus.y_oe_o = Y_W'(1) << row;

   for (genvar r = 0; r < Y_W; r++) begin : g_row
      for (genvar c = 0; c < X_W; c++) begin : g_col
         keyb_debounce #(
            .DEBOUNCE     (DEBOUNCE),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
         ) u_key (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .commit    (commit),
            .frame_bit (frame[key_idx(r, c, X_W)]),
            .stable    (stable[key_idx(r, c, X_W)]),
            .key_new   (new_hit[key_idx(r, c, X_W)]),
            .key_chg   (chg_hit[key_idx(r, c, X_W)])
         );
      end
   end

   assign bus.key_o     = stable;
   assign bus.key_new_o = new_hit;
   assign bus.key_chg_o = |chg_hit;
endmodule

// File: tb/tb_keyb_scan.sv
// Directed bench for keyb_scan with SCAN_DIV=4, DEBOUNCE=3 (32-clock frames);
// a behavioural keyboard pulls columns low for pressed keys on the driven row.
module tb_keyb_scan;
   import keyb_pkg::*;

   logic        clk = 1'b0;
   logic        rst_i;
   logic [23:0] press;

   int          n_vec = 0;
   int          n_bad = 0;
   int          pulses = 0;
   int          leaks = 0;
   logic [23:0] last_new = '0;

   keyb_scan_if #(.Y_W(8), .X_W(3)) bus ();

   keyb_scan #(
      .Y_W(8), .X_W(3), .SCAN_DIV(4), .DEBOUNCE(3),
      .REPEAT_DELAY(5), .REPEAT_RATE(2)
   ) dut (
      .clk_i (clk),
      .rst_i (rst_i),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always_comb begin
      bus.x_i = '1;
      for (int r = 0; r < 8; r++)
         if (bus.y_oe_o[r]) bus.x_i = ~press[r*3 +: 3];
   end

   always @(posedge clk) begin
      #2;
      if (!rst_i) begin
         if (bus.key_chg_o) begin
            pulses++;
            last_new = bus.key_new_o;
         end else if (bus.key_new_o != '0) begin
            leaks++;
         end
      end
   end

   typedef struct {
      logic [23:0] mask;
      int          frames;
      logic [23:0] exp_key;
      int          exp_pulses;
      logic [23:0] exp_new;
   } vec_t;

   vec_t vecs[12];

`ifdef KEYB_SCAN_AUTOREPEAT_EN
   localparam int P_ALL_ON  = 2;
   localparam int P_ALL_OFF = 2;
`else
   localparam int P_ALL_ON  = 1;
   localparam int P_ALL_OFF = 1;
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Leaves the bench on the negedge after release: the k-th later negedge follows edge k.
   task automatic do_reset();
      rst_i = 1'b1;
      press = '0;
      wait_neg(3);
      rst_i = 1'b0;
      pulses = 0;
   endtask

   initial begin
      rst_i = 1'b1;
      press = '0;
      vecs[0]  = '{24'h000000, 2, 24'h000000, 0, 24'h000000};
      vecs[1]  = '{24'h000080, 2, 24'h000000, 0, 24'h000000};
      vecs[2]  = '{24'h000000, 1, 24'h000000, 0, 24'h000000};
      vecs[3]  = '{24'h000080, 3, 24'h000080, 1, 24'h000080};
      vecs[4]  = '{24'h000080, 2, 24'h000080, 0, 24'h000000};
      vecs[5]  = '{24'h000001, 3, 24'h000001, 1, 24'h000001};
      vecs[6]  = '{24'h000000, 3, 24'h000000, 1, 24'h000000};
      vecs[7]  = '{24'h800041, 3, 24'h800041, 1, 24'h800041};
      vecs[8]  = '{24'h800001, 2, 24'h800041, 0, 24'h000000};
      vecs[9]  = '{24'h800001, 1, 24'h800001, 1, 24'h000000};
      vecs[10] = '{24'hFFFFFF, 3, 24'hFFFFFF, P_ALL_ON, 24'h7FFFFE};
      vecs[11] = '{24'h000000, 3, 24'h000000, P_ALL_OFF, 24'h000000};

      // Reset values and row walk
      do_reset();
      chk("rst_y_oe", 32'(bus.y_oe_o), 32'h01);
      chk("rst_key", 32'(bus.key_o), 32'h0);
      chk("rst_chg", 32'(bus.key_chg_o), 32'h0);
      chk("rst_new", 32'(bus.key_new_o), 32'h0);
      wait_neg(3);
      chk("scan_k3", 32'(bus.y_oe_o), 32'h01);
      wait_neg(1);
      chk("scan_k4", 32'(bus.y_oe_o), 32'h02);
      wait_neg(27);
      chk("scan_k31", 32'(bus.y_oe_o), 32'h80);
      wait_neg(1);
      chk("scan_k32", 32'(bus.y_oe_o), 32'h01);
      wait_neg(1);
      chk("scan_idle_key", 32'(bus.key_o), 32'h0);
      chk("scan_idle_pulses", 32'(pulses), 32'h0);

      // Single press: frames 0..2 sampled, third commit lands after edge 97
      do_reset();
      wait_neg(1);
      press = 24'h80;
      wait_neg(95);
      chk("press_k96_key", 32'(bus.key_o), 32'h0);
      chk("press_k96_chg", 32'(bus.key_chg_o), 32'h0);
      wait_neg(1);
      chk("press_k97_key", 32'(bus.key_o), 32'h80);
      chk("press_k97_chg", 32'(bus.key_chg_o), 32'h1);
      chk("press_k97_new", 32'(bus.key_new_o), 32'h80);
      wait_neg(1);
      chk("press_k98_chg", 32'(bus.key_chg_o), 32'h0);
      chk("press_k98_new", 32'(bus.key_new_o), 32'h0);
`ifdef KEYB_SCAN_AUTOREPEAT_EN
      // Repeats on the commits of frames 7, 9 and 11
      wait_neg(158);
      chk("rep_k256_chg", 32'(bus.key_chg_o), 32'h0);
      wait_neg(1);
      chk("rep_k257_chg", 32'(bus.key_chg_o), 32'h1);
      chk("rep_k257_new", 32'(bus.key_new_o), 32'h80);
      wait_neg(64);
      chk("rep_k321_chg", 32'(bus.key_chg_o), 32'h1);
      chk("rep_k321_new", 32'(bus.key_new_o), 32'h80);
      wait_neg(64);
      chk("rep_k385_chg", 32'(bus.key_chg_o), 32'h1);
      chk("rep_k385_new", 32'(bus.key_new_o), 32'h80);
      wait_neg(1);
      chk("rep_pulses", 32'(pulses), 32'd4);
      chk("rep_key", 32'(bus.key_o), 32'h80);
`endif

      // Reset in the middle of debouncing a press
      do_reset();
      wait_neg(1);
      press = 24'h80;
      wait_neg(64);
      rst_i = 1'b1;
      wait_neg(1);
      chk("mid_rst_y_oe", 32'(bus.y_oe_o), 32'h01);
      chk("mid_rst_key", 32'(bus.key_o), 32'h0);
      chk("mid_rst_chg", 32'(bus.key_chg_o), 32'h0);
      chk("mid_rst_new", 32'(bus.key_new_o), 32'h0);
      rst_i = 1'b0;
      pulses = 0;
      wait_neg(65);
      chk("mid_rst_2fr_key", 32'(bus.key_o), 32'h0);
      chk("mid_rst_2fr_pulses", 32'(pulses), 32'h0);
      wait_neg(32);
      chk("mid_rst_3fr_key", 32'(bus.key_o), 32'h80);
      chk("mid_rst_3fr_pulses", 32'(pulses), 32'h1);

      // Frame-aligned table: masks change just after each frame boundary
      do_reset();
      wait_neg(1);
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         press = vecs[i].mask;
         wait_neg(32 * vecs[i].frames);
         chk($sformatf("vec%0d_key", i), 32'(bus.key_o), 32'(vecs[i].exp_key));
         chk($sformatf("vec%0d_pulses", i), 32'(pulses), 32'(vecs[i].exp_pulses));
         if (vecs[i].exp_pulses > 0)
            chk($sformatf("vec%0d_new", i), 32'(last_new), 32'(vecs[i].exp_new));
         pulses = 0;
      end

      chk("new_without_chg", 32'(leaks), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
